// File: rtl/instruction_utils.sv
// rtl/instruction_utils.sv - RV32I decoded instruction enum and classification helpers
package instruction_utils;

    typedef enum logic [5:0] {
        INSTR_NOP,
        INSTR_LUI, INSTR_AUIPC, INSTR_JAL, INSTR_JALR,
        INSTR_BEQ, INSTR_BNE, INSTR_BLT, INSTR_BGE, INSTR_BLTU, INSTR_BGEU,
        INSTR_LB, INSTR_LH, INSTR_LW, INSTR_LBU, INSTR_LHU,
        INSTR_SB, INSTR_SH, INSTR_SW,
        INSTR_ADDI, INSTR_SLTI, INSTR_SLTIU, INSTR_XORI, INSTR_ORI, INSTR_ANDI,
        INSTR_SLLI, INSTR_SRLI, INSTR_SRAI,
        INSTR_ADD, INSTR_SUB, INSTR_SLL, INSTR_SLT, INSTR_SLTU,
        INSTR_XOR, INSTR_SRL, INSTR_SRA, INSTR_OR, INSTR_AND
    } rv32i_instr_e;

    function automatic logic is_r_type(rv32i_instr_e i);
        return i inside {INSTR_ADD, INSTR_SUB, INSTR_SLL, INSTR_SLT, INSTR_SLTU,
                         INSTR_XOR, INSTR_SRL, INSTR_SRA, INSTR_OR, INSTR_AND};
    endfunction

    function automatic logic is_jump(rv32i_instr_e i);
        return i inside {INSTR_JAL, INSTR_JALR};
    endfunction

endpackage

// File: rtl/execute_stage_if.sv
// rtl/execute_stage_if.sv - ID/EX inputs, EX/WB and fetch-redirect outputs of the execute stage
interface execute_stage_if;
    import instruction_utils::*;

    logic         stall;
    rv32i_instr_e id_ex_instr_type;
    logic [31:0]  id_ex_rs1;
    logic [31:0]  id_ex_rs2;
    logic [31:0]  id_ex_imm;
    logic [31:0]  id_ex_pc;
    logic [4:0]   id_ex_rd_addr;
    logic         id_ex_write_en;
    logic         ex_if_take_branch;
    logic [31:0]  ex_if_branch_target;
    logic [31:0]  ex_wb_result;
    logic         ex_wb_write_en;
    logic [4:0]   ex_wb_rd_addr;
    logic [31:0]  mem_addr;

    modport master (
        output stall, id_ex_instr_type, id_ex_rs1, id_ex_rs2, id_ex_imm, id_ex_pc,
               id_ex_rd_addr, id_ex_write_en,
        input  ex_if_take_branch, ex_if_branch_target, ex_wb_result, ex_wb_write_en,
               ex_wb_rd_addr, mem_addr
    );

    modport slave (
        input  stall, id_ex_instr_type, id_ex_rs1, id_ex_rs2, id_ex_imm, id_ex_pc,
               id_ex_rd_addr, id_ex_write_en,
        output ex_if_take_branch, ex_if_branch_target, ex_wb_result, ex_wb_write_en,
               ex_wb_rd_addr, mem_addr
    );

endinterface

// File: rtl/alu.sv
// rtl/alu.sv - combinational RV32I ALU; operand selection is done by the caller
module alu
    import instruction_utils::*;
(
    input  rv32i_instr_e instr_type,
    input  logic [31:0]  a,
    input  logic [31:0]  b,
    output logic [31:0]  result
);

    always_comb begin
        result = '0;
        unique case (instr_type)
            INSTR_ADD, INSTR_ADDI, INSTR_AUIPC, INSTR_JAL, INSTR_JALR,
            INSTR_LB, INSTR_LH, INSTR_LW, INSTR_LBU, INSTR_LHU,
            INSTR_SB, INSTR_SH, INSTR_SW:   result = a + b;
            INSTR_SUB:                      result = a - b;
            INSTR_AND, INSTR_ANDI:          result = a & b;
            INSTR_OR,  INSTR_ORI:           result = a | b;
            INSTR_XOR, INSTR_XORI:          result = a ^ b;
            INSTR_SLT, INSTR_SLTI:          result = {31'b0, $signed(a) < $signed(b)};
            INSTR_SLTU, INSTR_SLTIU:        result = {31'b0, a < b};
            INSTR_SLL, INSTR_SLLI:          result = a << b[4:0];
            INSTR_SRL, INSTR_SRLI:          result = a >> b[4:0];
            INSTR_SRA, INSTR_SRAI:          result = $unsigned($signed(a) >>> b[4:0]);
            INSTR_LUI:                      result = b;
            default:                        result = '0;
        endcase
    end

endmodule

// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - RV32I EX stage: ALU, branch resolution, EX/WB registers
// Optional: EXECUTE_STAGE_ZERO_RD_GUARD_EN suppresses write enable for rd == x0.
module execute_stage
    import instruction_utils::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    execute_stage_if.slave  ex
);

    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] target_d;
    logic            take_d;
    logic            write_en_d;

    // PC-relative results reuse the ALU adder: AUIPC is pc+imm, jumps link pc+4.
    always_comb begin
        op_a = ex.id_ex_rs1;
        op_b = ex.id_ex_imm;
        if (ex.id_ex_instr_type == INSTR_AUIPC || is_jump(ex.id_ex_instr_type))
            op_a = ex.id_ex_pc;
        if (is_r_type(ex.id_ex_instr_type))
            op_b = ex.id_ex_rs2;
        else if (is_jump(ex.id_ex_instr_type))
            op_b = 32'd4;
    end

    alu u_alu (
        .instr_type (ex.id_ex_instr_type),
        .a          (op_a),
        .b          (op_b),
        .result     (alu_result)
    );

    assign ex.mem_addr = ex.id_ex_rs1 + ex.id_ex_imm;

    always_comb begin
        take_d   = 1'b0;
        target_d = '0;
        unique case (ex.id_ex_instr_type)
            INSTR_BEQ:  take_d = ex.id_ex_rs1 == ex.id_ex_rs2;
            INSTR_BNE:  take_d = ex.id_ex_rs1 != ex.id_ex_rs2;
            INSTR_BLT:  take_d = $signed(ex.id_ex_rs1) <  $signed(ex.id_ex_rs2);
            INSTR_BGE:  take_d = $signed(ex.id_ex_rs1) >= $signed(ex.id_ex_rs2);
            INSTR_BLTU: take_d = ex.id_ex_rs1 <  ex.id_ex_rs2;
            INSTR_BGEU: take_d = ex.id_ex_rs1 >= ex.id_ex_rs2;
            INSTR_JAL:  take_d = 1'b1;
            INSTR_JALR: take_d = 1'b1;
            default:    take_d = 1'b0;
        endcase
        if (ex.id_ex_instr_type == INSTR_JALR)
            target_d = ex.mem_addr & ~32'd1;
        else if (ex.id_ex_instr_type inside {INSTR_BEQ, INSTR_BNE, INSTR_BLT, INSTR_BGE,
                                             INSTR_BLTU, INSTR_BGEU, INSTR_JAL})
            target_d = ex.id_ex_pc + ex.id_ex_imm;
    end

`ifdef EXECUTE_STAGE_ZERO_RD_GUARD_EN
    assign write_en_d = ex.id_ex_write_en && (ex.id_ex_rd_addr != 5'd0);
`else
    assign write_en_d = ex.id_ex_write_en;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex.ex_if_take_branch   <= 1'b0;
            ex.ex_if_branch_target <= '0;
            ex.ex_wb_result        <= '0;
            ex.ex_wb_write_en      <= 1'b0;
            ex.ex_wb_rd_addr       <= '0;
        end else if (!ex.stall) begin
            ex.ex_if_take_branch   <= take_d;
            ex.ex_if_branch_target <= target_d;
            ex.ex_wb_result        <= alu_result;
            ex.ex_wb_write_en      <= write_en_d;
            ex.ex_wb_rd_addr       <= ex.id_ex_rd_addr;
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// tb/tb_execute_stage.sv - directed table-driven bench for execute_stage
module tb_execute_stage;
    import instruction_utils::*;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    execute_stage_if bus ();

    execute_stage #(.XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .ex  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        rv32i_instr_e instr;
        logic [31:0]  rs1;
        logic [31:0]  rs2;
        logic [31:0]  imm;
        logic [31:0]  pc;
        logic [4:0]   rd;
        logic         we;
        logic         stall;
        logic [31:0]  exp_mem;
        logic [31:0]  exp_res;
        logic         exp_we;
        logic [4:0]   exp_rd;
        logic         exp_take;
        logic [31:0]  exp_tgt;
    } vec_t;

    vec_t vecs[$];

`ifdef EXECUTE_STAGE_ZERO_RD_GUARD_EN
    localparam logic RD0_WE = 1'b0;
`else
    localparam logic RD0_WE = 1'b1;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.stall            = v.stall;
        bus.id_ex_instr_type = v.instr;
        bus.id_ex_rs1        = v.rs1;
        bus.id_ex_rs2        = v.rs2;
        bus.id_ex_imm        = v.imm;
        bus.id_ex_pc         = v.pc;
        bus.id_ex_rd_addr    = v.rd;
        bus.id_ex_write_en   = v.we;
    endtask

    task automatic check_regs(input string tag, input logic [31:0] res, input logic we,
                              input logic [4:0] rd, input logic take, input logic [31:0] tgt);
        check({tag, ".result"}, bus.ex_wb_result, res);
        check({tag, ".write_en"}, {31'b0, bus.ex_wb_write_en}, {31'b0, we});
        check({tag, ".rd_addr"}, {27'b0, bus.ex_wb_rd_addr}, {27'b0, rd});
        check({tag, ".take"}, {31'b0, bus.ex_if_take_branch}, {31'b0, take});
        check({tag, ".target"}, bus.ex_if_branch_target, tgt);
    endtask

    initial begin
        vec_t v;
        checks   = 0;
        failures = 0;

        //            instr        rs1           rs2           imm           pc           rd  we  st  mem           res           we  rd  tk  tgt
        vecs.push_back('{INSTR_NOP,  32'h0,        32'h0,        32'h0,        32'h0,       0, 0, 0, 32'h0,        32'h0,        0, 0, 0, 32'h0});
        vecs.push_back('{INSTR_ADDI, 32'd10,       32'h0,        32'd5,        32'h0,       1, 1, 0, 32'd15,       32'd15,       1, 1, 0, 32'h0});
        vecs.push_back('{INSTR_ADD,  32'd20,       32'd30,       32'h0,        32'h0,       2, 1, 0, 32'd20,       32'd50,       1, 2, 0, 32'h0});
        vecs.push_back('{INSTR_SUB,  32'd100,      32'd40,       32'd10,       32'h0,       3, 1, 0, 32'd110,      32'd60,       1, 3, 0, 32'h0});
        vecs.push_back('{INSTR_BEQ,  32'd50,       32'd50,       32'h10,       32'h1010,    0, 0, 0, 32'h42,       32'h0,        0, 0, 1, 32'h1020});
        vecs.push_back('{INSTR_BNE,  32'd50,       32'd50,       32'h10,       32'h1010,    0, 0, 0, 32'h42,       32'h0,        0, 0, 0, 32'h1020});
        vecs.push_back('{INSTR_JALR, 32'h101,      32'h0,        32'h0,        32'h2000,    1, 1, 0, 32'h101,      32'h2004,     1, 1, 1, 32'h100});
        vecs.push_back('{INSTR_LW,   32'h2000,     32'h0,        32'h8,        32'h0,       4, 1, 0, 32'h2008,     32'h2008,     1, 4, 0, 32'h0});
        vecs.push_back('{INSTR_SW,   32'hF0,       32'h55,       32'hF,        32'h0,       0, 0, 0, 32'hFF,       32'hFF,       0, 0, 0, 32'h0});
        vecs.push_back('{INSTR_ADDI, 32'd1,        32'h0,        32'd1,        32'h0,       5, 1, 1, 32'd2,        32'hFF,       0, 0, 0, 32'h0});
        vecs.push_back('{INSTR_ADDI, 32'd1,        32'h0,        32'd1,        32'h0,       5, 1, 0, 32'd2,        32'd2,        1, 5, 0, 32'h0});
        vecs.push_back('{INSTR_SRA,  32'h80000000, 32'd4,        32'h0,        32'h0,       6, 1, 0, 32'h80000000, 32'hF8000000, 1, 6, 0, 32'h0});
        vecs.push_back('{INSTR_SLTU, 32'd1,        32'hFFFFFFFF, 32'h0,        32'h0,       7, 1, 0, 32'd1,        32'd1,        1, 7, 0, 32'h0});
        vecs.push_back('{INSTR_JAL,  32'h0,        32'h0,        32'h40,       32'h300,     1, 1, 0, 32'h40,       32'h304,      1, 1, 1, 32'h340});
        vecs.push_back('{INSTR_SLT,  32'hFFFFFFFF, 32'd1,        32'h0,        32'h0,       8, 1, 0, 32'hFFFFFFFF, 32'd1,        1, 8, 0, 32'h0});
        vecs.push_back('{INSTR_BLT,  32'hFFFFFFFF, 32'd1,        32'hFFFFFFF8, 32'h100,     0, 0, 0, 32'hFFFFFFF7, 32'h0,        0, 0, 1, 32'hF8});
        vecs.push_back('{INSTR_BGEU, 32'd1,        32'hFFFFFFFF, 32'd4,        32'h100,     0, 0, 0, 32'd5,        32'h0,        0, 0, 0, 32'h104});
        vecs.push_back('{INSTR_LUI,  32'h0,        32'h0,        32'h12345000, 32'h0,       9, 1, 0, 32'h12345000, 32'h12345000, 1, 9, 0, 32'h0});
        vecs.push_back('{INSTR_AUIPC,32'h0,        32'h0,        32'h2000,     32'h1000,    9, 1, 0, 32'h2000,     32'h3000,     1, 9, 0, 32'h0});
        vecs.push_back('{INSTR_XORI, 32'hFF00FF00, 32'h0,        32'hFFFFFFFF, 32'h0,      10, 1, 0, 32'hFF00FEFF, 32'h00FF00FF, 1,10, 0, 32'h0});
        vecs.push_back('{INSTR_SRLI, 32'h80000000, 32'h0,        32'h21,       32'h0,      11, 1, 0, 32'h80000021, 32'h40000000, 1,11, 0, 32'h0});
        vecs.push_back('{INSTR_ADD,  32'd3,        32'd4,        32'h0,        32'h0,       0, 1, 0, 32'd3,        32'd7,   RD0_WE, 0, 0, 32'h0});

        // Reset state
        v = vecs[0];
        drive(v);
        rst = 1'b1;
        #1;
        check_regs("reset", 32'h0, 1'b0, 5'd0, 1'b0, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            string tag;
            @(negedge clk);
            drive(vecs[i]);
            tag = $sformatf("v%0d_%s", i, vecs[i].instr.name());
            #1;
            check({tag, ".mem_addr"}, bus.mem_addr, vecs[i].exp_mem);
            @(posedge clk);
            #1;
            check_regs(tag, vecs[i].exp_res, vecs[i].exp_we, vecs[i].exp_rd,
                       vecs[i].exp_take, vecs[i].exp_tgt);
        end

        // Mid-stream reset between edges, then first edge after release latches normally
        @(negedge clk);
        v = vecs[6];
        drive(v);
        @(posedge clk);
        #1;
        check_regs("pre_rst", 32'h2004, 1'b1, 5'd1, 1'b1, 32'h100);
        #2;
        rst = 1'b1;
        #1;
        check_regs("mid_rst", 32'h0, 1'b0, 5'd0, 1'b0, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        v = vecs[1];
        v.rd = 5'd12;
        drive(v);
        @(posedge clk);
        #1;
        check_regs("post_rst", 32'd15, 1'b1, 5'd12, 1'b0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
